gng_romload_packer: RTL
=======================

# gng_romload_packer

Byte-to-word packer between the `hps_io` ROM download port and the 16-bit game ROM/SDRAM write port. It collects `ioctl_*` byte writes into little-endian 16-bit words and buffers them in a small FIFO. Words are issued over a req/ack handshake, and downloader back-pressure is asserted via `ioctl_wait`. It also detects the invulnerability-capable ROM signature (first four bytes `10 83 00 80`) that gates the Invulnerable menu option.

## Interface
Parameters:
- `AW`, 19: byte address width accepted; bytes at addresses ≥ 2^AW are discarded.
- `DEPTH`, 4: FIFO depth in words. Power of two, ≥ 2.

Ports:
- `clk_sys`, in, 1: sole clock.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `ioctl_download`, in, 1: download window active.
- `ioctl_wr`, in, 1: one-cycle byte strobe.
- `ioctl_addr`, in, 25: byte address.
- `ioctl_dout`, in, 8: byte data.
- `ioctl_wait`, out, 1: back-pressure to `hps_io`.
- `mem_req`, out, 1: write request.
- `mem_addr`, out, AW-1: word address.
- `mem_data`, out, 16: word data; byte at the even address goes in [7:0].
- `mem_be`, out, 2: byte enables; [0] covers the low byte.
- `mem_ack`, in, 1: write accepted.
- `inv_ena`, out, 1: signature matched.
- `done`, out, 1: one-cycle pulse when the download has ended and all words are written.
- `overflow`, out, 1: sticky; a byte arrived while the FIFO was full.

## Operation
- State machine has four states: IDLE, LOAD, FLUSH, DONE.
  - IDLE → LOAD on rising `ioctl_download`. This entry clears the partial-word register, `inv_ena`, `overflow` and the signature flags.
  - LOAD → FLUSH on falling `ioctl_download`.
  - FLUSH pushes any partial word, then waits until the FIFO is empty. FLUSH → DONE.
  - DONE pulses `done` for one cycle, then → IDLE.
- Byte packing happens in LOAD on `ioctl_wr` when `ioctl_addr < 2^AW`:
  - Even byte: held as a partial word with be=01 and word address `ioctl_addr[AW-1:1]`. If a partial word is already held, it is pushed first with its own be.
  - Odd byte, partial held at the same word address: the byte merges into [15:8], be=11, and the word is pushed.
  - Odd byte with no partial held, or a partial at a different word address: any held partial is pushed first. The odd byte is then pushed alone, be=10, with data in [15:8].
  - If one strobe needs two pushes, the second push occurs on the next cycle. `ioctl_wait` is asserted during that cycle.
- Signature detection:
  - Bytes written at addresses 0, 1, 2 and 3 set flag[i] to the result of comparing against `10`, `83`, `00` and `80` respectively.
  - `inv_ena` is registered as the AND of all four flags.
  - It holds after the download ends, until the next download starts.
- FIFO:
  - Push and pop in the same cycle are allowed; the count is unchanged.
  - A push while full is dropped and sets `overflow`. Pointers and contents are untouched.
- Handshake:
  - `mem_req` equals "FIFO not empty".
  - `mem_addr`, `mem_data` and `mem_be` show the FIFO head and stay stable while `mem_req` is high and no ack has been seen.
  - A word pops on a cycle where `mem_req` and `mem_ack` are both high. The next entry, if any, is presented on the following cycle with `mem_req` held high.
  - `mem_ack` while `mem_req` is low is ignored.
- `ioctl_wait` is high when the FIFO count ≥ DEPTH-1, or a second push is pending. This guarantees one in-flight strobe always fits.

## Timing
- Reset values: state IDLE, FIFO empty, all outputs 0.
- Asserting `rst_n` low mid-download drops all FIFO contents and any partial word immediately. No `done` pulse is produced for that download.
- Latency: the `ioctl_wr` that completes a word is at edge t. If the FIFO was empty, `mem_req` is high in cycle t+1.
- Flush: falling `ioctl_download` at edge t pushes the partial at t+1. `done` is high in the cycle after the last pop, and is never less than 2 cycles after the fall.
- An `ioctl_wr` coincident with the falling edge of `ioctl_download` is still packed.
- An `ioctl_wr` in IDLE or DONE is ignored.
- Throughput: one word per cycle when `mem_ack` is tied high.

## Test plan
- Sequential bytes `10 83 00 80 AA BB` at addresses 0–5, `mem_ack` tied high:
  - Writes are (0,`8310`,11), (1,`8000`,11), (2,`BBAA`,11).
  - `inv_ena`=1 after the byte at address 3.
  - `done` pulses once after the download falls.
- Odd byte count, bytes `11 22 33` at addresses 0–2, then download falls:
  - The last write is (1,`0033`,01).
  - `done` comes after that write.
- `mem_ack` held low while 8 words are streamed:
  - `ioctl_wait` rises when count=3.
  - `overflow` stays 0.
  - Releasing ack drains the words in order with no duplicates.
- Forced write with `ioctl_wait` ignored, FIFO full:
  - `overflow`=1 and the FIFO head is unchanged.
- Non-sequential addresses, byte 5 = `77` then byte 8 = `88`, download falls:
  - Writes are (2,`7700`,10) and (4,`0088`,01).
- `rst_n` low during a stalled stream:
  - `mem_req`=0, `inv_ena`=0 and `done`=0 immediately.
  - A fresh download then works normally.

Source files
------------

// File: rtl/gng_romload_packer.sv
// gng_romload_packer: packs hps_io ROM download bytes into 16-bit
// little-endian words and queues them in a small FIFO for a req/ack
// write port. It also recognises the invulnerability ROM signature.
// Ports: clk_sys, rst_n (async, active-low); ioctl_download/wr/addr/dout
// byte input with ioctl_wait back-pressure; mem_req/addr/data/be/ack
// word output; inv_ena signature match, done end pulse, sticky overflow.
module gng_romload_packer #(
   parameter int AW    = 19,
   parameter int DEPTH = 4
) (
   input  logic          clk_sys,
   input  logic          rst_n,
   input  logic          ioctl_download,
   input  logic          ioctl_wr,
   input  logic [24:0]   ioctl_addr,
   input  logic [7:0]    ioctl_dout,
   output logic          ioctl_wait,
   output logic          mem_req,
   output logic [AW-2:0] mem_addr,
   output logic [15:0]   mem_data,
   output logic [1:0]    mem_be,
   input  logic          mem_ack,
   output logic          inv_ena,
   output logic          done,
   output logic          overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int WW = AW + 17;
   localparam logic [31:0] SIG = 32'h8000_8310;

   typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

   state_t        state_q, state_d;
   logic          dl_q, start, drop;
   logic          part_vld_q, part_vld_d;
   logic          pend_vld_q, pend_vld_d;
   logic [WW-1:0] part_q, part_d, pend_q, pend_d;
   logic [WW-1:0] push_w, head, lo_w, hi_w, mg_w;
   logic          push, push_ok, pop, full, strobe, same_w;
   logic [AW-2:0] waddr;
   logic [3:0]    flag_q;
   logic [PW-1:0] wr_q, rd_q;
   logic [PW:0]   cnt_q;
   logic [WW-1:0] mem [DEPTH];

   // word layout: {word address, data[15:0], be[1:0]}
   assign strobe = ioctl_wr & ~|ioctl_addr[24:AW];
   assign waddr  = ioctl_addr[AW-1:1];
   assign same_w = part_q[WW-1 -: AW-1] == waddr;
   assign lo_w   = {waddr, 8'h00, ioctl_dout, 2'b01};
   assign hi_w   = {waddr, ioctl_dout, 8'h00, 2'b10};
   assign mg_w   = {waddr, ioctl_dout, part_q[9:2], 2'b11};

   assign full       = cnt_q == (PW+1)'(DEPTH);
   assign mem_req    = cnt_q != '0;
   assign pop        = mem_req & mem_ack;
   assign push_ok    = push & ~full;
   assign ioctl_wait = (cnt_q >= (PW+1)'(DEPTH-1)) | pend_vld_q;
   assign done       = state_q == DONE;

   // head is gated so the port reads zero while nothing is queued
   assign head     = mem[rd_q];
   assign mem_addr = mem_req ? head[WW-1 -: AW-1] : '0;
   assign mem_data = mem_req ? head[17:2] : '0;
   assign mem_be   = mem_req ? head[1:0] : '0;

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      start      = 1'b0;
      drop       = 1'b0;
      push       = 1'b0;
      push_w     = '0;
      part_vld_d = part_vld_q;
      part_d     = part_q;
      pend_vld_d = 1'b0;
      pend_d     = pend_q;
      unique case (state_q)
         IDLE: begin
            if (ioctl_download && !dl_q) begin
               state_d    = LOAD;
               start      = 1'b1;
               part_vld_d = 1'b0;
            end
         end
         LOAD: begin
            if (!ioctl_download && dl_q) state_d = FLUSH;
            if (pend_vld_q) begin
               // second half of a split strobe owns the push slot;
               // an even byte needs no push so it is still accepted
               if (full) begin
                  pend_vld_d = 1'b1;
               end else begin
                  push   = 1'b1;
                  push_w = pend_q;
               end
               if (strobe && !ioctl_addr[0]) begin
                  part_vld_d = 1'b1;
                  part_d     = lo_w;
               end
               drop = strobe & ioctl_addr[0];
            end else if (strobe) begin
               if (!ioctl_addr[0]) begin
                  push       = part_vld_q;
                  push_w     = part_q;
                  part_vld_d = 1'b1;
                  part_d     = lo_w;
               end else if (part_vld_q && same_w) begin
                  push       = 1'b1;
                  push_w     = mg_w;
                  part_vld_d = 1'b0;
               end else if (part_vld_q) begin
                  push       = 1'b1;
                  push_w     = part_q;
                  part_vld_d = 1'b0;
                  pend_vld_d = 1'b1;
                  pend_d     = hi_w;
               end else begin
                  push   = 1'b1;
                  push_w = hi_w;
               end
            end
         end
         FLUSH: begin
            if (full) begin
               pend_vld_d = pend_vld_q;
            end else if (pend_vld_q) begin
               push   = 1'b1;
               push_w = pend_q;
            end else if (part_vld_q) begin
               push       = 1'b1;
               push_w     = part_q;
               part_vld_d = 1'b0;
            end else if (cnt_q == '0) begin
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         dl_q       <= 1'b0;
         part_vld_q <= 1'b0;
         part_q     <= '0;
         pend_vld_q <= 1'b0;
         pend_q     <= '0;
         flag_q     <= '0;
         inv_ena    <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         dl_q       <= ioctl_download;
         part_vld_q <= part_vld_d;
         part_q     <= part_d;
         pend_vld_q <= pend_vld_d;
         pend_q     <= pend_d;
         if (start) begin
            flag_q   <= '0;
            inv_ena  <= 1'b0;
            overflow <= 1'b0;
         end else begin
            if (state_q == LOAD && ioctl_wr && ioctl_addr < 25'd4)
               flag_q[ioctl_addr[1:0]] <=
                  ioctl_dout == SIG[{ioctl_addr[1:0], 3'b000} +: 8];
            inv_ena <= &flag_q;
            if ((push && full) || drop) overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_ok) wr_q <= wr_q + PW'(1);
         if (pop)     rd_q <= rd_q + PW'(1);
         cnt_q <= cnt_q + (PW+1)'(push_ok) - (PW+1)'(pop);
      end
   end

   always_ff @(posedge clk_sys) begin
      if (push_ok) mem[wr_q] <= push_w;
   end

endmodule
